// File: rtl/counter_pkg.sv
// Shared definitions for the counter acquisition buffer controller:
// FSM state encoding and default bus widths.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 18;

endpackage

// File: rtl/counter_buf_ctrl.sv
// Acquisition controller that streams count words into an external dual-channel
// SRAM (channel A writes) and services system-bus reads through channel B.
import counter_pkg::*;

module counter_buf_ctrl #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_continuous,
    input  logic [ADDR_WIDTH:0]   i_num_samples,
    input  logic                  i_count_valid,
    input  logic [DATA_WIDTH-1:0] i_count,
    output logic [ADDR_WIDTH-1:0] o_sram_addr_a,
    output logic                  o_sram_we_a,
    output logic [DATA_WIDTH-1:0] o_sram_data_a,
    output logic [ADDR_WIDTH-1:0] o_sram_addr_b,
    output logic                  o_sram_we_b,
    input  logic [DATA_WIDTH-1:0] i_sram_data_b,
    input  logic                  i_bus_ren,
    input  logic [ADDR_WIDTH-1:0] i_bus_addr,
    output logic [DATA_WIDTH-1:0] o_bus_rdata,
    output logic                  o_bus_ack,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_wrapped,
    output logic [ADDR_WIDTH-1:0] o_wr_ptr,
    output state_t                o_state
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_inc, len_q, len_eff;
    logic                  cont_q, wrapped_q;
    logic                  write, start_take;

    // A zero length requests a full buffer.
    assign len_eff    = (len_q == '0) ? (ADDR_WIDTH + 1)'(DEPTH) : len_q;
    assign cnt_inc    = cnt_q + 1'b1;
    assign start_take = i_start && !((state_q == ST_ACQ) && i_stop);

    always_comb begin
        state_d = state_q;
        write   = 1'b0;
        case (state_q)
            ST_ACQ: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (i_start) begin
                    state_d = ST_ACQ;
                end else if (i_count_valid) begin
                    write = 1'b1;
                    if (!cont_q && (cnt_inc == len_eff)) state_d = ST_DONE;
                end
            end
            default: begin
                if (i_start) state_d = ST_ACQ;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            cont_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_take) begin
                wr_ptr_q  <= '0;
                cnt_q     <= '0;
                wrapped_q <= 1'b0;
                cont_q    <= i_continuous;
                len_q     <= i_num_samples;
            end else if (write) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                cnt_q    <= cnt_inc;
                if (cont_q && (wr_ptr_q == '1)) wrapped_q <= 1'b1;
            end
        end
    end

    assign o_sram_we_a   = write;
    assign o_sram_addr_a = wr_ptr_q;
    assign o_sram_data_a = i_count;
    assign o_wr_ptr      = wr_ptr_q;
    assign o_wrapped     = wrapped_q;
    assign o_busy        = (state_q == ST_ACQ);
    assign o_done        = (state_q == ST_DONE);
    assign o_state       = state_q;

    // Bus read: a request is taken only when neither pipeline stage is busy;
    // requests arriving while one is in flight are dropped without an ack.
    // The address is registered, the SRAM answers a cycle later, and the ack
    // cycle passes the SRAM data straight through.
    logic                  rd_pend_q, ack_q;
    logic [ADDR_WIDTH-1:0] addr_b_q;
    logic                  accept;

    assign accept = i_bus_ren && !rd_pend_q && !ack_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_pend_q <= 1'b0;
            ack_q     <= 1'b0;
            addr_b_q  <= '0;
        end else begin
            rd_pend_q <= accept;
            ack_q     <= rd_pend_q;
            if (accept) addr_b_q <= i_bus_addr;
        end
    end

    assign o_sram_addr_b = addr_b_q;
    assign o_sram_we_b   = 1'b0;
    assign o_bus_ack     = ack_q;
    assign o_bus_rdata   = ack_q ? i_sram_data_b : '0;

endmodule
